// File: rtl/led_row_pwm_if.sv
// Pixel-row link between the frame reader (master) and the LED row driver (slave).
interface led_row_pwm_if #(
    parameter int ROW_W = 3
);
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       pix_data;
    logic             pix_last;
    logic             row_req;
    logic [ROW_W-1:0] row_idx;

    modport master (
        output pix_valid, pix_data, pix_last,
        input  pix_ready, row_req, row_idx
    );

    modport slave (
        input  pix_valid, pix_data, pix_last,
        output pix_ready, row_req, row_idx
    );
endinterface

// File: rtl/led_row_pwm.sv
// Row-multiplexed PWM LED driver: scales incoming pixels by brightness into a shadow
// row buffer while the active row is PWM-displayed through an external row shift register.
module led_row_pwm #(
    parameter int N_COLS       = 18,
    parameter int N_ROWS       = 7,
    parameter int PRESCALE     = 4,
    parameter int BLANK_CYCLES = 8,
    parameter int ROW_W        = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [7:0]        brightness_i,
    led_row_pwm_if.slave      pix_if,
    output logic              frame_start_o,
    output logic              underrun_o,
    output logic              shift_reset,
    output logic              shift_clock,
    output logic [N_COLS-1:0] led_out
);
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W  = $clog2(BLANK_CYCLES);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(N_COLS - 1);
    localparam logic [PS_W-1:0]  LAST_PRESC = PS_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]  LAST_BLANK = BL_W'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(N_ROWS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ACTIVE, STALL} state_t;

    state_t                  state_q;
    logic [ROW_W-1:0]        row_q;
    logic [N_COLS-1:0][7:0]  shadow_q;
    logic [N_COLS-1:0][7:0]  active_q;
    logic                    shadowFull_q;
    logic                    pending_q;
    logic [COL_W-1:0]        wrCol_q;
    logic [BL_W-1:0]         blankCnt_q;
    logic [7:0]              pwmCnt_q;
    logic [PS_W-1:0]         presc_q;
    logic [N_COLS-1:0]       ledOut_q;
    logic                    shiftReset_q;
    logic                    shiftClock_q;
    logic                    rowReq_q;
    logic [ROW_W-1:0]        rowIdx_q;
    logic                    frameStart_q;
    logic                    underrun_q;

    logic                    pixReady_d;
    logic                    accept_d;
    logic [15:0]             prod_d;
    logic [7:0]              scaled_d;
    logic                    prescLast_d;
    logic                    rowEnd_d;
    logic                    swap_d;
    logic [ROW_W-1:0]        swapRow_d;
    logic [N_COLS-1:0]       ledCmp_d;

    function automatic logic [ROW_W-1:0] nextRow(input logic [ROW_W-1:0] r);
        return (r == LAST_ROW) ? '0 : r + 1'b1;
    endfunction

    // (brightness+1) scaling keeps full brightness lossless and brightness 0 fully dark.
    assign prod_d      = 16'(pix_if.pix_data) * (16'(brightness_i) + 16'd1);
    assign scaled_d    = 8'(prod_d >> 8);
    assign pixReady_d  = ~shadowFull_q & pending_q;
    assign accept_d    = pix_if.pix_valid & pixReady_d;
    assign prescLast_d = (presc_q == LAST_PRESC);
    assign rowEnd_d    = (state_q == ACTIVE) && prescLast_d && (pwmCnt_q == 8'hFF);

    always_comb begin
        ledCmp_d = '0;
        for (int c = 0; c < N_COLS; c++) begin
            ledCmp_d[c] = (active_q[c] > pwmCnt_q);
        end
    end

    always_comb begin
        swap_d    = 1'b0;
        swapRow_d = row_q;
        case (state_q)
            IDLE: begin
                if (shadowFull_q) begin
                    swap_d    = 1'b1;
                    swapRow_d = '0;
                end
            end
            ACTIVE, STALL: begin
                if (shadowFull_q && (state_q == STALL || rowEnd_d)) begin
                    swap_d    = 1'b1;
                    swapRow_d = nextRow(row_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            shadowFull_q <= 1'b0;
            pending_q    <= 1'b0;
            wrCol_q      <= '0;
            blankCnt_q   <= '0;
            pwmCnt_q     <= '0;
            presc_q      <= '0;
            ledOut_q     <= '0;
            shiftReset_q <= 1'b1;
            shiftClock_q <= 1'b0;
            rowReq_q     <= 1'b0;
            rowIdx_q     <= '0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (!enable_i) begin
            // Disabling abandons both buffers and any beat on the bus this cycle.
            state_q      <= IDLE;
            row_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            shadowFull_q <= 1'b0;
            pending_q    <= 1'b0;
            wrCol_q      <= '0;
            blankCnt_q   <= '0;
            pwmCnt_q     <= '0;
            presc_q      <= '0;
            ledOut_q     <= '0;
            shiftReset_q <= 1'b1;
            shiftClock_q <= 1'b0;
            rowReq_q     <= 1'b0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            rowReq_q     <= 1'b0;
            frameStart_q <= 1'b0;
            underrun_q   <= 1'b0;

            if (accept_d) begin
                shadow_q[wrCol_q] <= scaled_d;
                if (wrCol_q == LAST_COL || pix_if.pix_last) begin
                    shadowFull_q <= 1'b1;
                    pending_q    <= 1'b0;
                    wrCol_q      <= '0;
                end else begin
                    wrCol_q <= wrCol_q + 1'b1;
                end
            end

            if (swap_d) begin
                active_q     <= shadow_q;
                shadow_q     <= '0;
                shadowFull_q <= 1'b0;
                pending_q    <= 1'b1;
                row_q        <= swapRow_d;
                rowReq_q     <= 1'b1;
                rowIdx_q     <= nextRow(swapRow_d);
                frameStart_q <= (swapRow_d == '0);
                state_q      <= BLANK;
                blankCnt_q   <= '0;
                ledOut_q     <= '0;
                shiftReset_q <= 1'b0;
                shiftClock_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        ledOut_q     <= '0;
                        shiftReset_q <= 1'b1;
                        shiftClock_q <= 1'b0;
                        if (!shadowFull_q && !pending_q) begin
                            rowReq_q  <= 1'b1;
                            rowIdx_q  <= '0;
                            pending_q <= 1'b1;
                        end
                    end
                    BLANK: begin
                        ledOut_q     <= '0;
                        shiftReset_q <= (blankCnt_q == '0) && (row_q == '0);
                        shiftClock_q <= (blankCnt_q == '0) && (row_q != '0);
                        if (blankCnt_q == LAST_BLANK) begin
                            state_q  <= ACTIVE;
                            pwmCnt_q <= '0;
                            presc_q  <= '0;
                        end else begin
                            blankCnt_q <= blankCnt_q + 1'b1;
                        end
                    end
                    ACTIVE: begin
                        shiftReset_q <= 1'b0;
                        shiftClock_q <= 1'b0;
                        // Reaching here at row end means no next row was loaded in time.
                        if (rowEnd_d) begin
                            ledOut_q   <= '0;
                            underrun_q <= 1'b1;
                            state_q    <= STALL;
                        end else begin
                            ledOut_q <= ledCmp_d;
                            if (prescLast_d) begin
                                presc_q  <= '0;
                                pwmCnt_q <= pwmCnt_q + 8'd1;
                            end else begin
                                presc_q <= presc_q + 1'b1;
                            end
                        end
                    end
                    STALL: begin
                        ledOut_q     <= '0;
                        shiftReset_q <= 1'b0;
                        shiftClock_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pix_if.pix_ready = pixReady_d;
    assign pix_if.row_req   = rowReq_q;
    assign pix_if.row_idx   = rowIdx_q;
    assign frame_start_o    = frameStart_q;
    assign underrun_o       = underrun_q;
    assign shift_reset      = shiftReset_q;
    assign shift_clock      = shiftClock_q;
    assign led_out          = ledOut_q;
endmodule

// File: tb/tb_led_row_pwm.sv
// Scoreboard bench for led_row_pwm: directed rows push expected events, a negedge
// monitor pops them as the DUT pulses requests, shifts, underruns and row LED high-times.
module tb_led_row_pwm;
    localparam int N_COLS       = 4;
    localparam int N_ROWS       = 3;
    localparam int PRESCALE     = 1;
    localparam int BLANK_CYCLES = 4;
    localparam int ROW_W        = 2;
    localparam int ROW_GAP      = (BLANK_CYCLES - 1) + 256 * PRESCALE;
    localparam int WAIT_LIMIT   = 2000;

    typedef enum logic [2:0] {EV_REQ, EV_FRAME, EV_UNDERRUN, EV_SHIFT_RST, EV_SHIFT_CLK, EV_LED} evKind_t;
    typedef struct packed {
        evKind_t     kind;
        logic [63:0] val;
    } sbEntry_t;
    typedef logic [3:0][7:0] row_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              enable_i = 1'b1;
    logic [7:0]        brightness_i = 8'd0;
    logic              frame_start_o;
    logic              underrun_o;
    logic              shift_reset;
    logic              shift_clock;
    logic [N_COLS-1:0] led_out;

    led_row_pwm_if #(.ROW_W(ROW_W)) pixBus ();

    led_row_pwm #(
        .N_COLS(N_COLS), .N_ROWS(N_ROWS), .PRESCALE(PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES), .ROW_W(ROW_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .brightness_i(brightness_i),
        .pix_if(pixBus), .frame_start_o(frame_start_o), .underrun_o(underrun_o),
        .shift_reset(shift_reset), .shift_clock(shift_clock), .led_out(led_out)
    );

    always #5 clk_i = ~clk_i;

    sbEntry_t expQ[$];
    int assertCount = 0;
    int failCount = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input evKind_t kind, input logic [63:0] val);
        sbEntry_t e;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input evKind_t kind, input logic [63:0] val);
        sbEntry_t e;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpectedEvent: got kind %0d value 0x%0h, expected no event", kind, val);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", 64'(kind), 64'(e.kind));
            checkOutput($sformatf("eventValue(kind %0d)", e.kind), val, e.val);
        end
    endtask

    function automatic row_t mkRow(input int a, input int b, input int c, input int d);
        row_t r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(d);
        return r;
    endfunction

    function automatic logic [63:0] mkCounts(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Monitor: tracks per-row LED high-time from the row's shift pulse to its end.
    int cycle = 0;
    int reqCycle = 0;
    int shiftCycle = 0;
    bit counting = 1'b0;
    bit prevShiftReset = 1'b1;
    bit chkShiftFall = 1'b0;
    int hiCnt [N_COLS];

    function automatic logic [63:0] packCounts();
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < N_COLS; c++) r[16*c +: 16] = 16'(hiCnt[c]);
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            prevShiftReset = 1'b1;
            counting       = 1'b0;
            chkShiftFall   = 1'b0;
        end else begin
            cycle++;
            if (chkShiftFall) begin
                checkOutput("shiftPulseWidth", {62'd0, shift_reset, shift_clock}, 64'd0);
                chkShiftFall = 1'b0;
            end
            if (!enable_i) counting = 1'b0;
            if (counting && (pixBus.row_req || underrun_o)) begin
                popCheck(EV_LED, packCounts());
                checkOutput("rowPeriod", 64'(cycle - shiftCycle), 64'(ROW_GAP));
                counting = 1'b0;
            end
            if (pixBus.row_req) begin
                popCheck(EV_REQ, 64'(pixBus.row_idx));
                reqCycle = cycle;
            end
            if (frame_start_o) popCheck(EV_FRAME, 64'd0);
            if (underrun_o) popCheck(EV_UNDERRUN, 64'd0);
            if ((shift_reset && !prevShiftReset && enable_i) || shift_clock) begin
                popCheck(shift_reset ? EV_SHIFT_RST : EV_SHIFT_CLK, 64'd0);
                checkOutput("shiftAfterRequest", 64'(cycle - reqCycle), 64'd1);
                chkShiftFall = 1'b1;
                counting     = 1'b1;
                shiftCycle   = cycle;
                for (int c = 0; c < N_COLS; c++) hiCnt[c] = 0;
            end
            prevShiftReset = shift_reset;
            if (counting) begin
                for (int c = 0; c < N_COLS; c++) hiCnt[c] += int'(led_out[c]);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input logic [7:0] bright, input logic last);
        int n = 0;
        pixBus.pix_valid = 1'b1;
        pixBus.pix_data  = data;
        pixBus.pix_last  = last;
        brightness_i     = bright;
        while (!pixBus.pix_ready && n < WAIT_LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        if (!pixBus.pix_ready) checkOutput("beatAccepted", 64'(pixBus.pix_ready), 64'd1);
        @(negedge clk_i);
        pixBus.pix_valid = 1'b0;
        pixBus.pix_last  = 1'b0;
    endtask

    task automatic sendRow(input row_t data, input row_t bright, input int nBeats);
        for (int i = 0; i < nBeats; i++) begin
            applyStimulus(data[i], bright[i], (i == nBeats - 1) && (nBeats < N_COLS));
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < WAIT_LIMIT) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        row_t full;
        full = mkRow(255, 255, 255, 255);
        pixBus.pix_valid = 1'b0;
        pixBus.pix_data  = 8'd0;
        pixBus.pix_last  = 1'b0;

        repeat (3) @(negedge clk_i);
        checkOutput("resetLed", 64'(led_out), 64'd0);
        checkOutput("resetShiftReset", 64'(shift_reset), 64'd1);
        checkOutput("resetShiftClock", 64'(shift_clock), 64'd0);
        checkOutput("resetRowReq", 64'(pixBus.row_req), 64'd0);
        checkOutput("resetFrameStart", 64'(frame_start_o), 64'd0);
        checkOutput("resetUnderrun", 64'(underrun_o), 64'd0);
        checkOutput("resetPixReady", 64'(pixBus.pix_ready), 64'd0);

        pushExp(EV_REQ, 64'd0);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        checkOutput("idleRequestSeen", 64'(expQ.size()), 64'd0);
        checkOutput("idleShiftReset", 64'(shift_reset), 64'd1);
        checkOutput("idleLed", 64'(led_out), 64'd0);
        checkOutput("idlePixReady", 64'(pixBus.pix_ready), 64'd1);

        pushExp(EV_REQ, 64'd1);
        pushExp(EV_FRAME, 64'd0);
        pushExp(EV_SHIFT_RST, 64'd0);
        sendRow(mkRow(0, 1, 128, 255), full, 4);

        pushExp(EV_LED, mkCounts(0, 1, 128, 255));
        pushExp(EV_REQ, 64'd2);
        pushExp(EV_SHIFT_CLK, 64'd0);
        sendRow(mkRow(200, 200, 10, 255), mkRow(128, 0, 255, 127), 4);

        pushExp(EV_LED, mkCounts(100, 0, 10, 127));
        pushExp(EV_REQ, 64'd0);
        pushExp(EV_SHIFT_CLK, 64'd0);
        sendRow(mkRow(64, 192, 16, 240), mkRow(63, 63, 63, 63), 4);

        pushExp(EV_LED, mkCounts(16, 48, 4, 60));
        pushExp(EV_REQ, 64'd1);
        pushExp(EV_FRAME, 64'd0);
        pushExp(EV_SHIFT_RST, 64'd0);
        sendRow(mkRow(255, 1, 2, 3), full, 4);

        pushExp(EV_LED, mkCounts(255, 1, 2, 3));
        pushExp(EV_UNDERRUN, 64'd0);
        waitDrain("underrunReached");
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("stallLed", 64'(led_out), 64'd0);
            checkOutput("stallShift", {62'd0, shift_reset, shift_clock}, 64'd0);
        end

        pushExp(EV_REQ, 64'd2);
        pushExp(EV_SHIFT_CLK, 64'd0);
        sendRow(mkRow(100, 50, 0, 0), full, 2);

        pushExp(EV_LED, mkCounts(100, 50, 0, 0));
        pushExp(EV_REQ, 64'd0);
        pushExp(EV_SHIFT_CLK, 64'd0);
        sendRow(mkRow(77, 0, 0, 0), full, 1);
        waitDrain("row2Displayed");

        repeat (40) @(negedge clk_i);
        checkOutput("preDropLed", 64'(led_out), 64'd1);
        enable_i = 1'b0;
        @(negedge clk_i);
        checkOutput("dropLed", 64'(led_out), 64'd0);
        checkOutput("dropShiftReset", 64'(shift_reset), 64'd1);
        checkOutput("dropShiftClock", 64'(shift_clock), 64'd0);
        checkOutput("dropPixReady", 64'(pixBus.pix_ready), 64'd0);
        repeat (5) @(negedge clk_i);
        checkOutput("disabledLed", 64'(led_out), 64'd0);

        pushExp(EV_REQ, 64'd0);
        enable_i = 1'b1;
        waitDrain("reenableRequest");
        repeat (30) @(negedge clk_i);
        checkOutput("reenableLed", 64'(led_out), 64'd0);
        checkOutput("reenableShiftReset", 64'(shift_reset), 64'd1);
        checkOutput("reenablePixReady", 64'(pixBus.pix_ready), 64'd1);
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/led_row_pwm.md
Name: led_row_pwm

Overview:
- Display back-end stage. Consumes one row of 8-bit pixel values from the frame-reader, scales them by global brightness and double-buffers them.
- Time-multiplexes N_ROWS rows through the external row shift register. PWM-drives the N_COLS column outputs.
- Requests each next row from upstream while the current row is being displayed.

Parameters:
- N_COLS, 18, column outputs / pixels per row.
- N_ROWS, 7, rows per frame.
- PRESCALE, 4, clocks per PWM tick (>=1).
- BLANK_CYCLES, 8, all-off clocks between rows (>=4).
- ROW_W, 3, row index width (>= clog2(N_ROWS)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  display enable.
- brightness_i  in  8  global brightness, sampled per accepted pixel.
- pix_valid_i  in  1  pixel beat valid.
- pix_ready_o  out  1  shadow buffer can accept a beat.
- pix_data_i  in  8  pixel value.
- pix_last_i  in  1  final beat of row.
- row_req_o  out  1  one-cycle pulse requesting a row.
- row_idx_o  out  ROW_W  row being requested, valid with row_req_o.
- frame_start_o  out  1  one-cycle pulse when row 0 is swapped in.
- underrun_o  out  1  one-cycle pulse when a row finishes with no next row loaded.
- shift_reset  out  1  row shift register reset / row-0 select.
- shift_clock  out  1  row shift register advance.
- led_out  out  N_COLS  column drive, registered.

Behaviour:
- Reset values: led_out=0, shift_clock=0, shift_reset=1, row_req_o=0, frame_start_o=0, underrun_o=0, pix_ready_o=0.
- Reset state: FSM=IDLE, both buffers zero, shadow_full=0, pending=0, row=0.
- Load side:
  - pix_ready_o = ~shadow_full & pending.
  - Beat accepted on valid&ready: shadow[wr_col] <= (pix_data_i*(brightness_i+1))>>8, giving 8-bit results (255*256>>8=255; brightness 0 -> 0). wr_col then increments.
  - Row is complete on the beat where wr_col==N_COLS-1 or pix_last_i=1. On that beat: shadow_full<=1, pending<=0, wr_col<=0.
  - Columns not written before pix_last_i stay 0.
- Swap:
  - active<=shadow, shadow cleared to 0, shadow_full<=0, pending<=1.
  - row_req_o pulses the same cycle with row_idx_o = (row+1) mod N_ROWS, where row is the row just swapped in.
  - frame_start_o pulses if the swapped-in row is 0.
- IDLE state:
  - Outputs: led_out=0, shift_reset=1, shift_clock=0.
  - If enable_i & ~shadow_full & ~pending: pulse row_req_o with row_idx_o=0 and set pending.
  - If enable_i & shadow_full: swap, row<=0, go to BLANK.
- BLANK state:
  - Lasts BLANK_CYCLES clocks with led_out=0.
  - On the 2nd BLANK clock only, one output pulses high for one cycle: shift_reset if row==0, else shift_clock. Outside that cycle, shift_reset=0 and shift_clock=0.
  - Then go to ACTIVE with pwm_cnt=0 and prescaler=0.
- ACTIVE state:
  - pwm_cnt (8 bits) increments every PRESCALE clocks.
  - led_out[c] <= (active[c] > pwm_cnt), registered, so it lags pwm_cnt by 1 clock. Value 0 is never on; value 255 is on 255/256 of the row.
  - Row ends on the last prescale clock of pwm_cnt==255. Row period = BLANK_CYCLES + 256*PRESCALE clocks.
  - At row end with shadow_full: swap, row<=(row+1) mod N_ROWS, go to BLANK.
  - At row end with ~shadow_full: underrun_o pulses, go to STALL.
- STALL state:
  - led_out=0; shift outputs held 0.
  - When shadow_full: swap, advance row, go to BLANK.
- enable_i low in any state:
  - Next clock: FSM=IDLE, led_out=0, row=0.
  - Shadow and active cleared; shadow_full=0, pending=0, wr_col=0.
  - An in-flight pixel beat that cycle is dropped.
- Simultaneous events: a shadow_full set and a swap never coincide, because swap requires shadow_full already set. pix_ready_o is low while shadow_full=1.
- brightness_i changes apply only to beats accepted afterwards.

Test Plan:
- Bench configuration for every scenario: N_COLS=4, N_ROWS=3, PRESCALE=1, BLANK_CYCLES=4.
- Reset with enable_i=1, no pixel traffic -> row_req_o pulses once with row_idx_o=0; shift_reset stays 1; led_out=0; no further requests.
- Row 0 = {0,1,128,255}, brightness 255 -> swap; frame_start_o pulse; row_req idx=1; shift_reset high on 2nd BLANK clock only. Over 256 ACTIVE clocks, led_out bits stay high for 0/1/128/255 clocks respectively.
- Pixel 200 at brightness 128 -> stored value 100; 200 at brightness 0 -> 0. Verify via led_out high-time of 100 and 0 clocks.
- Feed rows 0,1,2,0 -> shift_clock pulses for rows 1 and 2; shift_reset pulse and frame_start_o for the wrapped row 0. row_idx_o sequence = 1,2,0,1.
- Withhold row 1 data -> underrun_o pulses at row end; led_out=0 in STALL; supplying the row resumes with BLANK and a shift_clock pulse.
- 2-beat row with pix_last_i on beat 2 -> columns 2,3 stay off. Drop enable_i mid-ACTIVE -> led_out=0 next clock, FSM IDLE, and a new idx-0 request follows when enable_i returns.
